// File: rtl/systolic_feed_ctrl.sv
// Multi-column systolic feeder. Drains per-column FIFOs on a fixed skewed slot
// schedule, inserts zero bubbles, flags underflow and pulses o_done at frame end.

module systolic_feed_lane #(
    parameter int DW   = 32,
    parameter int TW   = 1,
    parameter int OFF  = 0,
    parameter int LAST = 0,
    parameter int P    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_feed,
    input  logic [TW-1:0] i_t,
    input  logic          i_empty,
    input  logic [DW-1:0] i_data,
    input  logic          i_data_valid,
    output logic          o_rden,
    output logic          o_miss,
    output logic [DW-1:0] o_data,
    output logic          o_data_valid
);
    int            u;
    logic          slot;
    logic [DW-1:0] data_q;
    logic          vld_q;

    always_comb begin
        u    = int'(i_t) - OFF;
        slot = i_feed && (u >= 0) && (u <= LAST) && ((u % P) == 0);
    end

    // Reads are suppressed during reset so nothing arrives after an abort.
    assign o_rden = slot && !i_empty && !i_rst;
    assign o_miss = slot && i_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q  <= i_data_valid;
            data_q <= i_data_valid ? i_data : '0;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = vld_q;
endmodule

module systolic_feed_ctrl #(
    parameter int COL        = 4,
    parameter int ROW        = 9,
    parameter int DW         = 32,
    parameter int GAP        = 1,
    parameter int SKEW       = 1,
    parameter bit AUTO_START = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_trigger,
    input  logic [COL-1:0]    i_fifo_empty,
    input  logic [COL*DW-1:0] i_data,
    input  logic [COL-1:0]    i_data_valid,
    output logic [COL-1:0]    o_fifo_read_enable,
    output logic              o_select,
    output logic [COL*DW-1:0] o_data,
    output logic [COL-1:0]    o_data_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_underflow
);
    localparam int P     = GAP + 1;
    localparam int LAST  = (ROW - 1) * P;
    localparam int T_END = (COL - 1) * SKEW + LAST;
    localparam int TW    = (T_END < 1) ? 1 : $clog2(T_END + 1);
    localparam logic [TW-1:0] T_LAST = TW'(T_END);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  t_q, t_d;
    logic           drn_q, drn_d;
    logic           pend_q, pend_d;
    logic           uf_q, uf_d;
    logic           start;
    logic           feed;
    logic [COL-1:0] miss;

    assign feed = (state_q == S_FEED);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        drn_d   = drn_q;
        pend_d  = pend_q;
        uf_d    = uf_q | (|miss);
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                start = (i_trigger || pend_q || AUTO_START) && (i_fifo_empty == '0);
                if (start) begin
                    state_d = S_FEED;
                    t_d     = '0;
                    pend_d  = 1'b0;
                    uf_d    = 1'b0;
                end else if (i_trigger && (|i_fifo_empty)) begin
                    pend_d = 1'b1;
                end
            end
            S_FEED: begin
                if (t_q == T_LAST) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                    drn_d   = 1'b0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            // Two drain cycles carry the last read through i_data_valid and o_data.
            S_DRAIN: begin
                if (drn_q) state_d = S_DONE;
                else       drn_d   = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            drn_q   <= 1'b0;
            pend_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            drn_q   <= drn_d;
            pend_q  <= pend_d;
            uf_q    <= uf_d;
        end
    end

    for (genvar c = 0; c < COL; c++) begin : g_lane
        systolic_feed_lane #(
            .DW(DW), .TW(TW), .OFF(c * SKEW), .LAST(LAST), .P(P)
        ) u_lane (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_feed       (feed),
            .i_t          (t_q),
            .i_empty      (i_fifo_empty[c]),
            .i_data       (i_data[c*DW +: DW]),
            .i_data_valid (i_data_valid[c]),
            .o_rden       (o_fifo_read_enable[c]),
            .o_miss       (miss[c]),
            .o_data       (o_data[c*DW +: DW]),
            .o_data_valid (o_data_valid[c])
        );
    end

    assign o_select    = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_underflow = uf_q;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: small triggered instance with a per-cycle scoreboard,
// an auto-start back-to-back instance and a default-parameter instance.

module tb_systolic_feed_ctrl;
    localparam int C  = 2;
    localparam int R  = 3;
    localparam int D  = 16;
    localparam int G  = 1;
    localparam int S  = 1;
    localparam int P  = G + 1;
    localparam int TE = (C - 1) * S + (R - 1) * P;
    localparam int FL = TE + 4;
    localparam int PB = (R - 1) + 5;   // auto-start frame period with GAP=0, SKEW=0

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- instance A: triggered, scoreboard-checked
    logic           rst = 1'b1, trig = 1'b0;
    logic [C-1:0]   empty = '1, ivld = '0, rden, ovld;
    logic [C*D-1:0] idata = '0, odata;
    logic           sel, busy, done, uf;

    systolic_feed_ctrl #(.COL(C), .ROW(R), .DW(D), .GAP(G), .SKEW(S), .AUTO_START(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_trigger(trig), .i_fifo_empty(empty),
        .i_data(idata), .i_data_valid(ivld), .o_fifo_read_enable(rden),
        .o_select(sel), .o_data(odata), .o_data_valid(ovld),
        .o_busy(busy), .o_done(done), .o_underflow(uf));

    logic [D-1:0] fq [C][$];
    logic [D-1:0] mq [C][$];
    logic [C-1:0] rd_cap;

    // FIFO model: read in cycle k returns data with valid during cycle k+1.
    always begin
        @(negedge clk);
        rd_cap = rden;
        @(posedge clk);
        #1;
        for (int c = 0; c < C; c++) begin
            if (rd_cap[c] && fq[c].size() > 0) begin
                idata[c*D +: D] = fq[c].pop_front();
                ivld[c] = 1'b1;
            end else begin
                idata[c*D +: D] = '0;
                ivld[c] = 1'b0;
            end
            empty[c] = (fq[c].size() == 0);
        end
    end

    task automatic push(input int c, input logic [D-1:0] w);
        fq[c].push_back(w);
        mq[c].push_back(w);
    endtask

    typedef struct {
        int             cyc;
        logic [C-1:0]   rden;
        logic [C*D-1:0] data;
        logic [C-1:0]   vld;
        logic           sel, busy, done, uf;
    } exp_t;

    exp_t sbq[$];
    logic m_uf = 1'b0;
    bit   chk_en = 1'b0;

    // Expected per-cycle outputs of a frame whose start is sampled in cycle s.
    task automatic expect_frame(input int s);
        exp_t e [FL+1];
        bit   miss_at [FL+1];
        logic run_uf;
        for (int i = 1; i <= FL; i++) begin
            e[i].cyc = s + i; e[i].rden = '0; e[i].data = '0; e[i].vld = '0;
            e[i].sel = (i <= TE + 3); e[i].busy = 1'b1; e[i].done = (i == FL);
            e[i].uf = 1'b0; miss_at[i] = 1'b0;
        end
        for (int i = 1; i <= TE + 1; i++) begin
            for (int c = 0; c < C; c++) begin
                int u;
                u = i - 1 - c * S;
                if (u >= 0 && u <= (R - 1) * P && (u % P) == 0) begin
                    if (mq[c].size() > 0) begin
                        e[i].rden[c] = 1'b1;
                        e[i+2].vld[c] = 1'b1;
                        e[i+2].data[c*D +: D] = mq[c].pop_front();
                    end else begin
                        miss_at[i] = 1'b1;
                    end
                end
            end
        end
        run_uf = 1'b0;
        for (int i = 1; i <= FL; i++) begin
            e[i].uf = run_uf;
            if (miss_at[i]) run_uf = 1'b1;
            sbq.push_back(e[i]);
        end
    endtask

    always @(negedge clk) if (chk_en && !rst) begin
        exp_t x;
        x.cyc = cyc; x.rden = '0; x.data = '0; x.vld = '0;
        x.sel = 1'b0; x.busy = 1'b0; x.done = 1'b0; x.uf = m_uf;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) x = sbq.pop_front();
        m_uf = x.uf;
        chk("a_rden", 64'(rden),  64'(x.rden));
        chk("a_data", 64'(odata), 64'(x.data));
        chk("a_vld",  64'(ovld),  64'(x.vld));
        chk("a_sel",  64'(sel),   64'(x.sel));
        chk("a_busy", 64'(busy),  64'(x.busy));
        chk("a_done", 64'(done),  64'(x.done));
        chk("a_uf",   64'(uf),    64'(x.uf));
    end

    // ---------------- instance B: auto-start, GAP=0, SKEW=0, FIFOs never empty
    logic           rst_b = 1'b1;
    logic [C-1:0]   ivld_b = '0, rden_b, ovld_b;
    logic [C*D-1:0] idata_b = '0, odata_b;
    logic           sel_b, busy_b, done_b, uf_b;
    int             nb [C];
    logic [C-1:0]   rdb_cap;
    bit             b_en = 1'b0;
    int             b_r = 0;

    systolic_feed_ctrl #(.COL(C), .ROW(R), .DW(D), .GAP(0), .SKEW(0), .AUTO_START(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_trigger(1'b0), .i_fifo_empty('0),
        .i_data(idata_b), .i_data_valid(ivld_b), .o_fifo_read_enable(rden_b),
        .o_select(sel_b), .o_data(odata_b), .o_data_valid(ovld_b),
        .o_busy(busy_b), .o_done(done_b), .o_underflow(uf_b));

    initial for (int c = 0; c < C; c++) nb[c] = 0;

    always begin
        @(negedge clk);
        rdb_cap = rden_b;
        @(posedge clk);
        #1;
        for (int c = 0; c < C; c++) begin
            if (rdb_cap[c]) begin
                idata_b[c*D +: D] = D'(c * 256 + nb[c]);
                nb[c]++;
                ivld_b[c] = 1'b1;
            end else begin
                idata_b[c*D +: D] = '0;
                ivld_b[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) if (b_en) begin
        int k, ph, n;
        logic [C*D-1:0] xd;
        k  = cyc - b_r;
        ph = k % PB;
        n  = (k / PB) * R + ph - 3;
        xd = '0;
        for (int c = 0; c < C; c++)
            if (ph >= 3 && ph <= 5) xd[c*D +: D] = D'(c * 256 + n);
        chk("b_rden", 64'(rden_b), (ph >= 1 && ph <= 3) ? 64'(2'b11) : 64'(0));
        chk("b_vld",  64'(ovld_b), (ph >= 3 && ph <= 5) ? 64'(2'b11) : 64'(0));
        chk("b_data", 64'(odata_b), 64'(xd));
        chk("b_sel",  64'(sel_b),  64'(ph >= 1 && ph <= 5));
        chk("b_done", 64'(done_b), 64'(ph == 6));
        chk("b_uf",   64'(uf_b),   64'(0));
    end

    // ---------------- instance D: default parameters, FIFOs never empty
    logic          trig_d = 1'b0;
    logic [3:0]    rden_d, ovld_d;
    logic [127:0]  odata_d;
    logic          sel_d, busy_d, done_d, uf_d;
    int            cnt_d [4];
    int            done_cyc_d = -1;

    systolic_feed_ctrl dut_d (
        .i_clk(clk), .i_rst(rst_b), .i_trigger(trig_d), .i_fifo_empty(4'b0000),
        .i_data('0), .i_data_valid(4'b0000), .o_fifo_read_enable(rden_d),
        .o_select(sel_d), .o_data(odata_d), .o_data_valid(ovld_d),
        .o_busy(busy_d), .o_done(done_d), .o_underflow(uf_d));

    initial for (int c = 0; c < 4; c++) cnt_d[c] = 0;

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) if (rden_d[c]) cnt_d[c]++;
        if (done_d && done_cyc_d < 0) done_cyc_d = cyc;
    end

    // ---------------- directed sequence
    initial begin
        int s;
        tick(3);
        rst = 1'b0; rst_b = 1'b0;
        b_r = cyc; b_en = 1'b1; chk_en = 1'b1;
        tick(2);

        // Preloaded frame, trigger immediately.
        for (int i = 0; i < R; i++) begin push(0, 16'hA000 + 16'(i)); push(1, 16'hB000 + 16'(i)); end
        tick(1);
        trig = 1'b1; s = cyc; expect_frame(s);
        tick(1); trig = 1'b0;
        tick(FL + 2);

        // Trigger while lane 1 empty: pending until lane 1 fills.
        for (int i = 0; i < R; i++) push(0, 16'hC000 + 16'(i));
        tick(1);
        trig = 1'b1;
        tick(1); trig = 1'b0;
        tick(3);
        for (int i = 0; i < R; i++) push(1, 16'hD000 + 16'(i));
        tick(1);
        expect_frame(cyc);
        tick(FL + 3);

        // Lane 0 runs dry after one word: underflow sticks through DONE.
        push(0, 16'hE000);
        for (int i = 0; i < R; i++) push(1, 16'hE100 + 16'(i));
        tick(1);
        trig = 1'b1; s = cyc; expect_frame(s);
        tick(1); trig = 1'b0;
        tick(FL + 2);

        // Clean frame clears the sticky underflow on start.
        for (int i = 0; i < R; i++) begin push(0, 16'h1200 + 16'(i)); push(1, 16'h3400 + 16'(i)); end
        tick(1);
        trig = 1'b1; s = cyc; expect_frame(s);
        tick(1); trig = 1'b0;
        tick(FL + 2);

        // Reset at t=3 of a frame: abort, no done.
        for (int i = 0; i < R; i++) begin push(0, 16'h5500 + 16'(i)); push(1, 16'h6600 + 16'(i)); end
        tick(1);
        trig = 1'b1; s = cyc; expect_frame(s);
        tick(1); trig = 1'b0;
        tick(3);
        rst = 1'b1;
        sbq.delete(); m_uf = 1'b0;
        for (int c = 0; c < C; c++) begin fq[c].delete(); mq[c].delete(); end
        tick(1); rst = 1'b0;
        tick(FL + 2);

        // Reset and trigger together: reset wins, nothing starts.
        for (int i = 0; i < R; i++) begin push(0, 16'h7700 + 16'(i)); push(1, 16'h8800 + 16'(i)); end
        tick(1);
        rst = 1'b1; trig = 1'b1;
        tick(1); rst = 1'b0; trig = 1'b0;
        tick(6);

        // Full clean frame after the resets.
        trig = 1'b1; s = cyc; expect_frame(s);
        tick(1); trig = 1'b0;
        tick(FL + 2);

        // Default parameters: T_END=19, done 23 cycles after start sample.
        trig_d = 1'b1; s = cyc;
        tick(1); trig_d = 1'b0;
        chk("d_busy", 64'(busy_d), 64'(1));
        for (int i = 0; i < 60 && done_cyc_d < 0; i++) tick(1);
        chk("d_done_lat", 64'(done_cyc_d - s), 64'(23));
        for (int c = 0; c < 4; c++) chk("d_reads", 64'(cnt_d[c]), 64'(9));
        chk("d_uf", 64'(uf_d), 64'(0));
        tick(2);
        chk("d_idle", 64'(busy_d), 64'(0));

        tick(2);
        b_en = 1'b0; chk_en = 1'b0;
        chk("a_sb_empty", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
